// File: rtl/frequency_counter_wb.sv
// Wishbone-style slave that counts clk_i cycles spanned by GATE_EDGES periods of
// signal_input. Software clears and starts a measurement, then reads the latched result.
module frequency_counter_wb #(
    parameter int GATE_EDGES = 8,
    parameter int CNT_W      = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    input  logic        we_i,
    input  logic [3:0]  sel_i,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        lock_i,
    output logic        err_o,
    output logic        rty_o,
    output logic        ack_o,
    input  logic        tagn_i,
    output logic        tagn_o,
    input  logic        signal_input,
    input  logic        reference_clk_main,
    input  logic        reference_clk_interpolate
);

    localparam logic [31:0] ADDR_CTRL   = 32'h0000_0008;
    localparam logic [31:0] ADDR_RESULT = 32'h0000_0009;
    localparam logic [31:0] ADDR_EDGES  = 32'h0000_000C;
    localparam int          EDGE_W      = $clog2(GATE_EDGES + 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(GATE_EDGES - 1);
    localparam logic [EDGE_W-1:0] EDGE_ALL  = EDGE_W'(GATE_EDGES);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_COUNT} state_t;

    state_t             state_q, state_d;
    logic [1:0]         sync_q;
    logic               sig_prev_q;
    logic [CNT_W-1:0]   period_q, period_d, result_q, result_d, period_inc;
    logic [EDGE_W-1:0]  edge_q, edge_d, edges_q, edges_d;
    logic               done_q, done_d, ovf_q, ovf_d, inc_ovf;
    logic               ack_q, ack_d, err_q, err_d, rty_q, rty_d, tagn_q, tagn_d;
    logic [31:0]        dat_q, dat_d;

    logic accept, busy, rise, hit_ctrl, hit_result, hit_edges, ctrl_wr, clr, start;
    logic unused_inputs;

    // Returns {overflow, value}; the value sticks at all-ones once saturated.
    function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W:0] s;
        s = {1'b0, v} + (CNT_W+1)'(1);
        if (s[CNT_W]) return {1'b1, {CNT_W{1'b1}}};
        return s;
    endfunction

    assign {inc_ovf, period_inc} = sat_inc(period_q);
    assign rise       = sync_q[1] & ~sig_prev_q;
    assign busy       = (state_q != S_IDLE);
    assign accept     = stb_i & ~(ack_q | err_q | rty_q);
    assign hit_ctrl   = (addr_i == ADDR_CTRL);
    assign hit_result = (addr_i == ADDR_RESULT);
    assign hit_edges  = (addr_i == ADDR_EDGES);
    assign ctrl_wr    = accept & we_i & hit_ctrl;
    assign clr        = ctrl_wr & dat_i[0];
    assign start      = ctrl_wr & dat_i[7] & ~dat_i[0];

    assign unused_inputs = ^{sel_i, cyc_i, lock_i, reference_clk_main,
                             reference_clk_interpolate, dat_i[31:8], dat_i[6:1]};

    always_comb begin
        ack_d  = 1'b0;
        err_d  = 1'b0;
        rty_d  = 1'b0;
        dat_d  = 32'd0;
        tagn_d = tagn_q;
        if (accept) begin
            tagn_d = tagn_i;
            if (hit_ctrl) begin
                ack_d = 1'b1;
                if (!we_i) dat_d = {28'd0, ovf_q, done_q, busy, 1'b0};
            end else if (hit_edges) begin
                ack_d = 1'b1;
                if (!we_i) dat_d = 32'(edges_q);
            end else if (hit_result) begin
                if (!we_i && busy) begin
                    rty_d = 1'b1;
                end else begin
                    ack_d = 1'b1;
                    if (!we_i) dat_d = 32'(result_q);
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        edge_d   = edge_q;
        result_d = result_q;
        edges_d  = edges_q;
        done_d   = done_q;
        ovf_d    = ovf_q;
        case (state_q)
            S_IDLE: ;
            S_ARM: begin
                period_d = '0;
                edge_d   = '0;
                if (rise) state_d = S_COUNT;
            end
            S_COUNT: begin
                period_d = period_inc;
                if (inc_ovf) ovf_d = 1'b1;
                if (rise) begin
                    if (edge_q == EDGE_LAST) begin
                        state_d  = S_IDLE;
                        result_d = period_inc;
                        edges_d  = EDGE_ALL;
                        done_d   = 1'b1;
                    end else begin
                        edge_d = edge_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Software commands override whatever the measurement did this cycle.
        if (start) begin
            state_d  = S_ARM;
            period_d = '0;
            edge_d   = '0;
            done_d   = 1'b0;
            ovf_d    = 1'b0;
        end
        if (clr) begin
            state_d  = S_IDLE;
            period_d = '0;
            edge_d   = '0;
            result_d = '0;
            edges_d  = '0;
            done_d   = 1'b0;
            ovf_d    = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            sync_q     <= 2'b00;
            sig_prev_q <= 1'b0;
            period_q   <= '0;
            edge_q     <= '0;
            result_q   <= '0;
            edges_q    <= '0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            rty_q      <= 1'b0;
            tagn_q     <= 1'b0;
            dat_q      <= 32'd0;
        end else begin
            state_q    <= state_d;
            sync_q     <= {sync_q[0], signal_input};
            sig_prev_q <= sync_q[1];
            period_q   <= period_d;
            edge_q     <= edge_d;
            result_q   <= result_d;
            edges_q    <= edges_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            rty_q      <= rty_d;
            tagn_q     <= tagn_d;
            dat_q      <= dat_d;
        end
    end

    assign ack_o  = ack_q;
    assign err_o  = err_q;
    assign rty_o  = rty_q;
    assign tagn_o = tagn_q;
    assign dat_o  = dat_q;

endmodule

// File: tb/tb_frequency_counter_wb.sv
// Bench for frequency_counter_wb: a full-width counter and a narrow saturating one
// share the bus and signal; both are checked against a transaction-level model.
module tb_frequency_counter_wb;

    localparam int G    = 8;
    localparam int W2   = 5;
    localparam int MAXB = (1 << W2) - 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr, wdat;
    logic        we, stb, cyc, lock, tagn_i, sig;
    logic [3:0]  sel;
    logic [31:0] dat_a, dat_b;
    logic        ack_a, err_a, rty_a, tagn_a;
    logic        ack_b, err_b, rty_b, tagn_b;

    always #5 clk = ~clk;

    frequency_counter_wb #(.GATE_EDGES(G), .CNT_W(32)) dut_a (
        .clk_i(clk), .rst_i(rst), .addr_i(addr), .dat_i(wdat), .dat_o(dat_a),
        .we_i(we), .sel_i(sel), .cyc_i(cyc), .stb_i(stb), .lock_i(lock),
        .err_o(err_a), .rty_o(rty_a), .ack_o(ack_a), .tagn_i(tagn_i), .tagn_o(tagn_a),
        .signal_input(sig), .reference_clk_main(1'b0), .reference_clk_interpolate(1'b0)
    );

    frequency_counter_wb #(.GATE_EDGES(G), .CNT_W(W2)) dut_b (
        .clk_i(clk), .rst_i(rst), .addr_i(addr), .dat_i(wdat), .dat_o(dat_b),
        .we_i(we), .sel_i(sel), .cyc_i(cyc), .stb_i(stb), .lock_i(lock),
        .err_o(err_b), .rty_o(rty_b), .ack_o(ack_b), .tagn_i(tagn_i), .tagn_o(tagn_b),
        .signal_input(sig), .reference_clk_main(1'b0), .reference_clk_interpolate(1'b0)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Reference model: measurement state at the level of software-visible registers.
    logic        m_busy, m_done, m_ovf_a, m_ovf_b;
    logic [31:0] m_res_a, m_res_b, m_edges;

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_ovf_a = 0; m_ovf_b = 0;
        m_res_a = 0; m_res_b = 0; m_edges = 0;
    endtask

    task automatic model_ctrl(input logic [31:0] d);
        if (d[0]) model_reset();
        else if (d[7]) begin
            m_busy = 1; m_done = 0; m_ovf_a = 0; m_ovf_b = 0;
        end
    endtask

    task automatic model_complete(input int sum);
        m_busy  = 0;
        m_done  = 1;
        m_res_a = 32'(sum);
        m_res_b = (sum > MAXB) ? 32'(MAXB) : 32'(sum);
        m_ovf_b = (sum > MAXB);
        m_edges = 32'(G);
    endtask

    function automatic logic [31:0] status_word(input logic ovf);
        return {28'd0, ovf, m_done, m_busy, 1'b0};
    endfunction

    logic [2:0]  t_a, t_b;
    logic [31:0] d_a, d_b;
    logic        tg_a, tg_b, tg_sent;

    task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d);
        @(negedge clk);
        addr = a; we = w; wdat = d; stb = 1'b1;
        tagn_i = 1'($urandom); sel = 4'($urandom); cyc = 1'($urandom); lock = 1'($urandom);
        tg_sent = tagn_i;
        @(negedge clk);
        t_a = {ack_a, err_a, rty_a}; t_b = {ack_b, err_b, rty_b};
        d_a = dat_a; d_b = dat_b; tg_a = tagn_a; tg_b = tagn_b;
        stb = 1'b0; we = 1'b0;
    endtask

    // term is {ack, err, rty}
    task automatic expect_xfer(input string tag, input logic [31:0] a, input logic w,
                               input logic [31:0] d, input logic [2:0] term,
                               input logic [31:0] ea, input logic [31:0] eb);
        xfer(a, w, d);
        check({tag, "_term"}, 32'({t_a, t_b}), 32'({term, term}));
        check({tag, "_dat_a"}, d_a, ea);
        check({tag, "_dat_b"}, d_b, eb);
        check({tag, "_tagn"}, 32'({tg_a, tg_b}), 32'({tg_sent, tg_sent}));
    endtask

    task automatic ctrl_wr(input string tag, input logic [31:0] d);
        expect_xfer(tag, 32'h8, 1'b1, d, 3'b100, 32'd0, 32'd0);
        model_ctrl(d);
    endtask

    task automatic chk_status(input string tag);
        expect_xfer(tag, 32'h8, 1'b0, 32'd0, 3'b100, status_word(m_ovf_a), status_word(m_ovf_b));
    endtask

    task automatic chk_result(input string tag);
        if (m_busy) expect_xfer(tag, 32'h9, 1'b0, 32'd0, 3'b001, 32'd0, 32'd0);
        else        expect_xfer(tag, 32'h9, 1'b0, 32'd0, 3'b100, m_res_a, m_res_b);
    endtask

    task automatic chk_edges(input string tag);
        expect_xfer(tag, 32'hC, 1'b0, 32'd0, 3'b100, m_edges, m_edges);
    endtask

    // Emits n_rises rising edges; sum is the cycle span from the first to the last.
    task automatic drive_periods(input int n_rises, input bit fixed, output int sum);
        int h, l;
        sum = 0;
        for (int i = 0; i < n_rises; i++) begin
            h = fixed ? 4 : int'($urandom_range(1, 6));
            l = fixed ? 4 : int'($urandom_range(1, 6));
            sig = 1'b1;
            repeat (h) @(negedge clk);
            sig = 1'b0;
            repeat (l) @(negedge clk);
            if (i < n_rises - 1) sum += h + l;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic hold_read(input logic tg);
        int acks = 0, others = 0;
        @(negedge clk);
        addr = 32'h8; we = 1'b0; stb = 1'b1; tagn_i = tg;
        repeat (10) begin
            @(negedge clk);
            if (ack_a) acks++;
            if (err_a || rty_a) others++;
        end
        stb = 1'b0;
        check("hold_acks", 32'(acks), 32'd5);
        check("hold_other", 32'(others), 32'd0);
        check("hold_tagn", 32'({tagn_a, tagn_b}), 32'({tg, tg}));
    endtask

    initial begin
        int sum;
        logic [31:0] d, a;
        rst = 1'b1; addr = 0; wdat = 0; we = 0; stb = 0; cyc = 0; lock = 0;
        tagn_i = 0; sel = 0; sig = 0;
        model_reset();
        #100;
        check("rst_term", 32'({ack_a, err_a, rty_a, tagn_a, ack_b, err_b, rty_b, tagn_b}), 32'd0);
        check("rst_dat_a", dat_a, 32'd0);
        check("rst_dat_b", dat_b, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        ctrl_wr("clr0", 32'h01);
        chk_status("stat0");
        chk_result("res0");
        chk_edges("edg0");

        // Nominal measurement: 8 periods of 8 cycles.
        ctrl_wr("start1", 32'h80);
        chk_status("stat_busy1");
        chk_result("res_busy1");
        expect_xfer("unmapped_rd", 32'h4, 1'b0, 32'd0, 3'b010, 32'd0, 32'd0);
        drive_periods(G + 1, 1'b1, sum);
        model_complete(sum);
        chk_status("stat_done1");
        chk_result("res_done1");
        chk_edges("edg_done1");

        expect_xfer("wr_result", 32'h9, 1'b1, 32'hFFFF_FFFF, 3'b100, 32'd0, 32'd0);
        expect_xfer("wr_edges", 32'hC, 1'b1, 32'hFFFF_FFFF, 3'b100, 32'd0, 32'd0);
        chk_result("res_after_ro_wr");

        ctrl_wr("clr2", 32'h01);
        chk_result("res_clr2");
        chk_status("stat_clr2");
        chk_edges("edg_clr2");
        ctrl_wr("start2", 32'h80);
        drive_periods(G + 1, 1'b1, sum);
        model_complete(sum);
        chk_result("res_done2");

        // Static input: stays armed until cleared.
        ctrl_wr("start_static", 32'h80);
        repeat (30) @(negedge clk);
        chk_status("stat_static");
        ctrl_wr("clr_static", 32'h01);
        chk_status("stat_static_clr");
        ctrl_wr("clr_start", 32'h81);
        chk_status("stat_clr_start");

        for (int r = 0; r < 6; r++) begin
            d = ($urandom & 32'hFFFF_FF7E) | 32'h80;
            ctrl_wr("start_rnd", d);
            if ($urandom_range(0, 1) == 1) ctrl_wr("restart_rnd", d);
            chk_status("stat_rnd_busy");
            chk_result("res_rnd_busy");
            a = $urandom;
            if (a == 32'h8 || a == 32'h9 || a == 32'hC) a = 32'h4;
            expect_xfer("unmapped_wr", a, 1'b1, 32'h81, 3'b010, 32'd0, 32'd0);
            drive_periods(G + 1, 1'b0, sum);
            model_complete(sum);
            chk_status("stat_rnd_done");
            chk_result("res_rnd_done");
            chk_edges("edg_rnd_done");
        end

        hold_read(1'b0);
        hold_read(1'b1);

        // Asynchronous reset in the middle of a measurement, with ack still high.
        ctrl_wr("start_ar", 32'h80);
        drive_periods(3, 1'b1, sum);
        chk_status("stat_ar");
        #2 rst = 1'b1;
        #1;
        check("arst_term", 32'({ack_a, err_a, rty_a, tagn_a, ack_b, err_b, rty_b, tagn_b}), 32'd0);
        check("arst_dat", 32'(dat_a | dat_b), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk_status("stat_after_arst");
        chk_result("res_after_arst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
